// File: rtl/seg7_pkg.sv
// Shared glyphs, converter state and BCD helpers for the seven-segment scan driver.
// Glyphs are active-high {g,f,e,d,c,b,a}; output polarity is applied only at the pins.
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } cvt_state_t;

    localparam logic [6:0] GLYPH_E     = 7'h79;
    localparam logic [6:0] GLYPH_R     = 7'h50;
    localparam logic [6:0] GLYPH_DASH  = 7'h40;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    // One spare digit above the display is always kept so overflow is visible.
    function automatic int bcd_digits(int value_w, int num_digits);
        int n;
        n = (value_w + 2) / 3;
        if (n < num_digits + 1) n = num_digits + 1;
        return n;
    endfunction

    function automatic logic [6:0] digit_glyph(bcd_t d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Latency: start -> done is VALUE_W+1 cycles; done is a one-cycle pulse in COMMIT.
// Backpressure: start is ignored while busy; the caller holds off new work.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter  int VALUE_W    = 14,
    parameter  int NUM_DIGITS = 4,
    localparam int BCD_N      = bcd_digits(VALUE_W, NUM_DIGITS),
    localparam int CNT_W      = $clog2(VALUE_W + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [VALUE_W-1:0]   din,
    output logic                 busy,
    output logic                 done,
    output logic [BCD_N*4-1:0]   bcd
);

    cvt_state_t              state_q, state_d;
    logic [VALUE_W-1:0]      bin_q, bin_d;
    logic [BCD_N*4-1:0]      bcd_q, bcd_d;
    logic [BCD_N*4-1:0]      bcd_adj;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_SHIFT;
            ST_SHIFT:  if (cnt_q == CNT_W'(VALUE_W - 1)) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_COMMIT);
        bcd  = bcd_q;
    end

    // Add-3 correction on every nibble, then shift {bcd,bin} left by one.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_N; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        if (state_q == ST_IDLE && start) begin
            bin_d = din;
            bcd_d = '0;
            cnt_d = '0;
        end else if (state_q == ST_SHIFT) begin
            bcd_d = {bcd_adj[BCD_N*4-2:0], bin_q[VALUE_W-1]};
            bin_d = {bin_q[VALUE_W-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment driver with BCD conversion, overflow and "Err" display (SEG7_LZB_EN: leading-zero blanking).
// Latency: value_valid to display register VALUE_W+2 cycles; an/seg lag the scan index by 1 cycle.
// Backpressure: none; strobes while busy land in a 1-deep pending slot, last strobe wins.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int VALUE_W       = 14,
    parameter int REFRESH_DIV_W = 16,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  value_valid,
    input  logic                  show_error,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  busy,
    output logic                  overflow
);

    localparam int BCD_N = bcd_digits(VALUE_W, NUM_DIGITS);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0]            SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

    logic                         cvt_start, cvt_busy, cvt_done;
    logic [VALUE_W-1:0]           cvt_din;
    logic [BCD_N*4-1:0]           cvt_bcd;

    logic                         pend_vld_q, pend_vld_d;
    logic [VALUE_W-1:0]           pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0][3:0]   dig_q, dig_d;
    logic                         ovf_q, ovf_d;
    logic [REFRESH_DIV_W-1:0]     rfc_q, rfc_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [6:0]                   seg_q, seg_d;
    logic [NUM_DIGITS-1:0]        an_q, an_d;

    logic [NUM_DIGITS-1:0]        blank_vec;
    logic                         lead_zero;
    logic [6:0]                   seg_act;
    logic [NUM_DIGITS-1:0]        an_act;

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (cvt_start),
        .din   (cvt_din),
        .busy  (cvt_busy),
        .done  (cvt_done),
        .bcd   (cvt_bcd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_vld_q <= 1'b0;
            pend_val_q <= '0;
            dig_q      <= '0;
            ovf_q      <= 1'b0;
            rfc_q      <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_OFF;
            an_q       <= AN_OFF;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_val_q <= pend_val_d;
            dig_q      <= dig_d;
            ovf_q      <= ovf_d;
            rfc_q      <= rfc_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    // A fresh strobe in IDLE beats a stale pending value.
    always_comb begin
        cvt_start  = !cvt_busy && (value_valid || pend_vld_q);
        cvt_din    = value_valid ? value : pend_val_q;
        pend_vld_d = pend_vld_q;
        pend_val_d = pend_val_q;
        if (cvt_busy && value_valid) begin
            pend_vld_d = 1'b1;
            pend_val_d = value;
        end else if (cvt_start) begin
            pend_vld_d = 1'b0;
        end
        dig_d = dig_q;
        ovf_d = ovf_q;
        if (cvt_done) begin
            dig_d = cvt_bcd[NUM_DIGITS*4-1:0];
            ovf_d = |cvt_bcd[BCD_N*4-1:NUM_DIGITS*4];
        end
    end

    always_comb begin
        rfc_d = rfc_q + REFRESH_DIV_W'(1);
        idx_d = idx_q;
        if (rfc_q == '1) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_comb begin
        blank_vec = '0;
        lead_zero = 1'b1;
`ifdef SEG7_LZB_EN
        for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
            if (dig_q[d] != 4'd0) lead_zero = 1'b0;
            blank_vec[d] = lead_zero;
        end
`endif
        if (show_error) begin
            if (idx_q == IDX_W'(NUM_DIGITS - 1))
                seg_act = GLYPH_E;
            else if (idx_q == IDX_W'(NUM_DIGITS - 2) || idx_q == IDX_W'(NUM_DIGITS - 3))
                seg_act = GLYPH_R;
            else
                seg_act = GLYPH_BLANK;
        end else if (ovf_q) begin
            seg_act = GLYPH_DASH;
        end else if (blank_vec[idx_q]) begin
            seg_act = GLYPH_BLANK;
        end else begin
            seg_act = digit_glyph(dig_q[idx_q]);
        end
        an_act        = '0;
        an_act[idx_q] = 1'b1;
        seg_d = (ACTIVE_LOW != 0) ? ~seg_act : seg_act;
        an_d  = (ACTIVE_LOW != 0) ? ~an_act  : an_act;
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign busy     = cvt_busy;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 14-bit value, fast scan, active-low pins.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] value;
    logic        value_valid;
    logic        show_error;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        busy;
    logic        overflow;

    int vectors = 0;
    int miscompares = 0;

    seg7_scan_driver #(
        .NUM_DIGITS    (4),
        .VALUE_W       (14),
        .REFRESH_DIV_W (2),
        .ACTIVE_LOW    (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .value_valid (value_valid),
        .show_error  (show_error),
        .seg         (seg),
        .an          (an),
        .busy        (busy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Active-high glyph expected for decimal digit d of v.
    function automatic logic [6:0] exp_glyph(int v, int d);
        int p;
        int dg;
        logic [6:0] g;
        p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        dg = (v / p) % 10;
        case (dg)
            0: g = 7'h3F;  1: g = 7'h06;  2: g = 7'h5B;  3: g = 7'h4F;  4: g = 7'h66;
            5: g = 7'h6D;  6: g = 7'h7D;  7: g = 7'h07;  8: g = 7'h7F;  default: g = 7'h6F;
        endcase
`ifdef SEG7_LZB_EN
        if (d > 0 && v < p) g = 7'h00;
`endif
        return g;
    endfunction

    function automatic logic [27:0] num_pattern(int v);
        return {exp_glyph(v, 3), exp_glyph(v, 2), exp_glyph(v, 1), exp_glyph(v, 0)};
    endfunction

    task automatic strobe(input int v);
        @(negedge clk);
        value       = 14'(v);
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    // Scan until each digit is enabled and compare its segments (pins are active-low).
    task automatic check_pattern(input string tag, input logic [27:0] exp);
        logic [3:0] want;
        logic       found;
        for (int d = 0; d < 4; d++) begin
            want  = ~(4'b0001 << d);
            found = 1'b0;
            for (int n = 0; n < 40 && !found; n++) begin
                @(negedge clk);
                if (an === want) found = 1'b1;
            end
            chk($sformatf("%s_scan%0d", tag, d), {31'd0, found}, 32'd1);
            if (found) chk($sformatf("%s_dig%0d", tag, d), {25'd0, ~seg}, {25'd0, exp[7*d +: 7]});
        end
    endtask

    initial begin
        int n;
        int bcnt;
        logic [3:0] act;
        int cur;
        reset       = 1'b1;
        value       = '0;
        value_valid = 1'b0;
        show_error  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        check_pattern("idle0", num_pattern(0));

        // 1234: busy for 15 sampled cycles
        strobe(1234);
        bcnt = 0;
        while (busy === 1'b1 && bcnt < 100) begin
            bcnt++;
            @(negedge clk);
        end
        chk("busy_len", bcnt, 32'd15);
        chk("ovf_1234", {31'd0, overflow}, 32'd0);
        check_pattern("v1234", num_pattern(1234));

        // 12000 overflows, then 5 clears it
        strobe(12000);
        wait_idle("v12000");
        chk("ovf_12000", {31'd0, overflow}, 32'd1);
        check_pattern("dash", {4{7'h40}});
        strobe(5);
        wait_idle("v5");
        chk("ovf_5", {31'd0, overflow}, 32'd0);
        check_pattern("v5", num_pattern(5));

        // 100, then 37 and 250 while busy: 37 is overwritten by 250
        strobe(100);
        repeat (3) @(negedge clk);
        strobe(37);
        repeat (2) @(negedge clk);
        strobe(250);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("gap_low", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("pend_start", {31'd0, busy}, 32'd1);
        @(negedge clk);
        act = ~an;
        cur = 0;
        for (int d = 0; d < 4; d++) if (act[d]) cur = d;
        chk("v100_onehot", {28'd0, act}, 32'(4'b0001 << cur));
        chk("v100_cur", {25'd0, ~seg}, {25'd0, exp_glyph(100, cur)});
        wait_idle("v250");
        bcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0) bcnt++;
        end
        chk("no_third", bcnt, 32'd0);
        check_pattern("v250", num_pattern(250));

        // Error display overrides the number, then releases it
        show_error = 1'b1;
        check_pattern("err", {7'h79, 7'h50, 7'h50, 7'h00});
        show_error = 1'b0;
        check_pattern("err_off", num_pattern(250));

        // Boundaries around 10**4
        strobe(10000);
        wait_idle("v10000");
        chk("ovf_10000", {31'd0, overflow}, 32'd1);
        strobe(9999);
        wait_idle("v9999");
        chk("ovf_9999", {31'd0, overflow}, 32'd0);
        check_pattern("v9999", num_pattern(9999));

        // Reset mid-SHIFT with a pending value: everything dropped
        strobe(1234);
        repeat (3) @(negedge clk);
        strobe(4321);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_an", {28'd0, an}, 32'hF);
        chk("mid_rst_seg", {25'd0, seg}, 32'h7F);
        reset = 1'b0;
        bcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0) bcnt++;
        end
        chk("pend_dropped", bcnt, 32'd0);
        check_pattern("post_rst", num_pattern(0));

        // Small values: leading-zero behaviour depends on build
        strobe(7);
        wait_idle("v7");
        check_pattern("v7", num_pattern(7));
        strobe(0);
        wait_idle("v0");
        check_pattern("v0", num_pattern(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
